// File: rtl/apb_timer_master_if.sv
// Command/response channel and APB4 bus of the timer-port APB requester.
// master = the requester's view; slave = command source plus APB completer.
interface apb_timer_master_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [3:0]        cmd_strb;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [3:0]        pstrb;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_timer_master.sv
// APB4 requester feeding the 64-bit timer's register port, one command at a time.
// Optional ACCESS-phase wait limit enabled by defining APB_MST_TIMEOUT_EN.
module apb_timer_master #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   apb_timer_master_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10
   } state_t;

   if (TIMEOUT_CYC < 2) begin : g_timeout_range
      $error("apb_timer_master: TIMEOUT_CYC must be at least 2");
   end

   state_t            state_r,     state_s;
   logic              cmd_ready_r, cmd_ready_s;
   logic              psel_r,      psel_s;
   logic              penable_r,   penable_s;
   logic              pwrite_r,    pwrite_s;
   logic [ADDR_W-1:0] paddr_r,     paddr_s;
   logic [DATA_W-1:0] pwdata_r,    pwdata_s;
   logic [3:0]        pstrb_r,     pstrb_s;
   logic              rsp_valid_r, rsp_valid_s;
   logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
   logic              rsp_err_r,   rsp_err_s;

`ifdef APB_MST_TIMEOUT_EN
   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s;
`endif

   // Read data is only returned for an error-free read; writes and errors report zero.
   function automatic logic [DATA_W-1:0] read_result(
      input logic              is_write,
      input logic              slv_err,
      input logic [DATA_W-1:0] data
   );
      if (!is_write && !slv_err) begin
         return data;
      end else begin
         return {DATA_W{1'b0}};
      end
   endfunction

   // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequence.
   always_comb begin
      state_s     = state_r;
      cmd_ready_s = cmd_ready_r;
      psel_s      = psel_r;
      penable_s   = penable_r;
      pwrite_s    = pwrite_r;
      paddr_s     = paddr_r;
      pwdata_s    = pwdata_r;
      pstrb_s     = pstrb_r;
      rsp_valid_s = 1'b0;
      rsp_rdata_s = rsp_rdata_r;
      rsp_err_s   = rsp_err_r;
`ifdef APB_MST_TIMEOUT_EN
      wait_cnt_s  = wait_cnt_r;
`endif

      case (state_r)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready_r) begin
               if (bus.cmd_addr[1:0] == 2'b00) begin
                  state_s     = ST_SETUP;
                  cmd_ready_s = 1'b0;
                  psel_s      = 1'b1;
                  penable_s   = 1'b0;
                  pwrite_s    = bus.cmd_write;
                  paddr_s     = bus.cmd_addr;
                  pwdata_s    = bus.cmd_wdata;
                  pstrb_s     = bus.cmd_write ? bus.cmd_strb : 4'b0000;
               end else begin
                  // Misaligned: answer immediately without touching the bus.
                  state_s     = ST_IDLE;
                  cmd_ready_s = 1'b1;
                  rsp_valid_s = 1'b1;
                  rsp_err_s   = 1'b1;
                  rsp_rdata_s = {DATA_W{1'b0}};
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_SETUP: begin
            state_s   = ST_ACCESS;
            penable_s = 1'b1;
`ifdef APB_MST_TIMEOUT_EN
            wait_cnt_s = {CNT_W{1'b0}};
`endif
         end

         ST_ACCESS: begin
            if (bus.pready) begin
               state_s     = ST_IDLE;
               cmd_ready_s = 1'b1;
               psel_s      = 1'b0;
               penable_s   = 1'b0;
               rsp_valid_s = 1'b1;
               rsp_err_s   = bus.pslverr;
               rsp_rdata_s = read_result(pwrite_r, bus.pslverr, bus.prdata);
            end else begin
`ifdef APB_MST_TIMEOUT_EN
               if (wait_cnt_r == CNT_LAST) begin
                  state_s     = ST_IDLE;
                  cmd_ready_s = 1'b1;
                  psel_s      = 1'b0;
                  penable_s   = 1'b0;
                  rsp_valid_s = 1'b1;
                  rsp_err_s   = 1'b1;
                  rsp_rdata_s = {DATA_W{1'b0}};
               end else begin
                  wait_cnt_s = wait_cnt_r + CNT_W'(1);
               end
`else
               state_s = ST_ACCESS;
`endif
            end
         end

         default: begin
            state_s     = ST_IDLE;
            cmd_ready_s = 1'b1;
            psel_s      = 1'b0;
            penable_s   = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any transfer without a response.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r     <= ST_IDLE;
         cmd_ready_r <= 1'b1;
         psel_r      <= 1'b0;
         penable_r   <= 1'b0;
         pwrite_r    <= 1'b0;
         paddr_r     <= {ADDR_W{1'b0}};
         pwdata_r    <= {DATA_W{1'b0}};
         pstrb_r     <= 4'b0000;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {DATA_W{1'b0}};
         rsp_err_r   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
         wait_cnt_r  <= {CNT_W{1'b0}};
`endif
      end else begin
         state_r     <= state_s;
         cmd_ready_r <= cmd_ready_s;
         psel_r      <= psel_s;
         penable_r   <= penable_s;
         pwrite_r    <= pwrite_s;
         paddr_r     <= paddr_s;
         pwdata_r    <= pwdata_s;
         pstrb_r     <= pstrb_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_rdata_r <= rsp_rdata_s;
         rsp_err_r   <= rsp_err_s;
`ifdef APB_MST_TIMEOUT_EN
         wait_cnt_r  <= wait_cnt_s;
`endif
      end
   end

   assign bus.cmd_ready = cmd_ready_r;
   assign bus.psel      = psel_r;
   assign bus.penable   = penable_r;
   assign bus.pwrite    = pwrite_r;
   assign bus.paddr     = paddr_r;
   assign bus.pwdata    = pwdata_r;
   assign bus.pstrb     = pstrb_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_apb_timer_master.sv
// Directed bench for apb_timer_master: hand-computed expectations checked 1 time unit after each edge.
// Adds the wait-limit scenarios when APB_MST_TIMEOUT_EN is defined.
module tb_apb_timer_master;

   logic sys_clk;
   logic sys_rst;
   int   checks;
   int   errors;

   apb_timer_master_if #(.ADDR_W(12), .DATA_W(32)) bus ();

   apb_timer_master #(
      .ADDR_W      (12),
      .DATA_W      (32),
      .TIMEOUT_CYC (16)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus.master)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_bus(input string tag, input logic sel, input logic en, input logic rv);
      check({tag, ".psel"},      64'(bus.psel),      64'(sel));
      check({tag, ".penable"},   64'(bus.penable),   64'(en));
      check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(rv));
   endtask

   task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_strb  = strb;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      sys_rst       = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 12'h000;
      bus.cmd_wdata = 32'h0000_0000;
      bus.cmd_strb  = 4'b0000;
      bus.prdata    = 32'h0000_0000;
      bus.pready    = 1'b0;
      bus.pslverr   = 1'b0;
      tick();
      tick();

      // Reset state
      check_bus("rst", 1'b0, 1'b0, 1'b0);
      check("rst.cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check("rst.rsp_err",   64'(bus.rsp_err),   64'd0);
      check("rst.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      check("rst.paddr",     64'(bus.paddr),     64'd0);
      check("rst.pstrb",     64'(bus.pstrb),     64'd0);
      sys_rst = 1'b0;

      // 1: write 0x103 to 0x000, strb 0011, pready tied high
      bus.pready = 1'b1;
      issue(1'b1, 12'h000, 32'h0000_0103, 4'b0011);
      tick();
      bus.cmd_valid = 1'b0;
      check_bus("w1.setup", 1'b1, 1'b0, 1'b0);
      check("w1.cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("w1.pwrite",    64'(bus.pwrite),    64'd1);
      check("w1.pwdata",    64'(bus.pwdata),    64'h103);
      check("w1.pstrb",     64'(bus.pstrb),     64'h3);
      tick();
      check_bus("w1.access", 1'b1, 1'b1, 1'b0);
      tick();
      check_bus("w1.rsp", 1'b0, 1'b0, 1'b1);
      check("w1.rsp_err",   64'(bus.rsp_err),   64'd0);
      check("w1.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      check("w1.cmd_ready", 64'(bus.cmd_ready), 64'd1);
      tick();
      check("w1.pulse_end", 64'(bus.rsp_valid), 64'd0);

      // 2: read 0x00C, 3 wait states, slave returns all ones
      bus.pready = 1'b0;
      issue(1'b0, 12'h00C, 32'hDEAD_BEEF, 4'b1111);
      tick();
      bus.cmd_valid = 1'b0;
      check_bus("r2.setup", 1'b1, 1'b0, 1'b0);
      check("r2.pstrb",  64'(bus.pstrb),  64'd0);
      check("r2.pwrite", 64'(bus.pwrite), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_bus($sformatf("r2.access%0d", i), 1'b1, 1'b1, 1'b0);
         check($sformatf("r2.paddr%0d", i), 64'(bus.paddr), 64'h00C);
      end
      bus.pready = 1'b1;
      bus.prdata = 32'hFFFF_FFFF;
      tick();
      bus.pready = 1'b0;
      bus.prdata = 32'h0000_0000;
      check_bus("r2.rsp", 1'b0, 1'b0, 1'b1);
      check("r2.rsp_rdata", 64'(bus.rsp_rdata), 64'hFFFF_FFFF);
      check("r2.rsp_err",   64'(bus.rsp_err),   64'd0);
      tick();

      // 3: read 0x020 with pslverr at pready
      bus.pready  = 1'b1;
      bus.pslverr = 1'b1;
      bus.prdata  = 32'h1234_5678;
      issue(1'b0, 12'h020, 32'h0000_0000, 4'b0000);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      check_bus("r3.rsp", 1'b0, 1'b0, 1'b1);
      check("r3.rsp_err",   64'(bus.rsp_err),   64'd1);
      check("r3.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      bus.pslverr = 1'b0;
      tick();
      check("r3.pulse_end",   64'(bus.rsp_valid), 64'd0);
      check("r3.err_hold",    64'(bus.rsp_err),   64'd1);

      // 4: misaligned address 0x006
      issue(1'b1, 12'h006, 32'h0000_00AA, 4'b1111);
      tick();
      bus.cmd_valid = 1'b0;
      check_bus("m4.rsp", 1'b0, 1'b0, 1'b1);
      check("m4.rsp_err",   64'(bus.rsp_err),   64'd1);
      check("m4.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      check("m4.cmd_ready", 64'(bus.cmd_ready), 64'd1);
      tick();
      check_bus("m4.after", 1'b0, 1'b0, 1'b0);

      // 5: back-to-back, second command accepted on the rsp_valid cycle
      issue(1'b1, 12'h010, 32'hA5A5_A5A5, 4'b1111);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      check_bus("b5.rsp_a", 1'b0, 1'b0, 1'b1);
      check("b5.err_a", 64'(bus.rsp_err), 64'd0);
      issue(1'b0, 12'h014, 32'h0000_0000, 4'b1111);
      bus.prdata = 32'h0BAD_F00D;
      tick();
      bus.cmd_valid = 1'b0;
      check_bus("b5.setup_b", 1'b1, 1'b0, 1'b0);
      check("b5.paddr_b", 64'(bus.paddr), 64'h014);
      check("b5.pstrb_b", 64'(bus.pstrb), 64'd0);
      tick();
      tick();
      check_bus("b5.rsp_b", 1'b0, 1'b0, 1'b1);
      check("b5.rdata_b", 64'(bus.rsp_rdata), 64'h0BAD_F00D);
      bus.prdata = 32'h0000_0000;

      // 6: reset during ACCESS
      bus.pready = 1'b0;
      issue(1'b0, 12'h030, 32'h0000_0000, 4'b0000);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      check_bus("x6.access", 1'b1, 1'b1, 1'b0);
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      check_bus("x6.reset", 1'b0, 1'b0, 1'b0);
      check("x6.cmd_ready", 64'(bus.cmd_ready), 64'd1);
      check("x6.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      tick();
      check_bus("x6.after", 1'b0, 1'b0, 1'b0);

`ifdef APB_MST_TIMEOUT_EN
      // Wait limit: pready held low aborts after 16 ACCESS cycles
      issue(1'b0, 12'h040, 32'h0000_0000, 4'b0000);
      tick();
      bus.cmd_valid = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         check_bus($sformatf("t7.access%0d", i), 1'b1, 1'b1, 1'b0);
      end
      tick();
      check_bus("t7.abort", 1'b0, 1'b0, 1'b1);
      check("t7.rsp_err",   64'(bus.rsp_err),   64'd1);
      check("t7.rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      tick();

      // pready on the abort cycle completes normally
      issue(1'b0, 12'h044, 32'h0000_0000, 4'b0000);
      tick();
      bus.cmd_valid = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
      end
      bus.pready = 1'b1;
      bus.prdata = 32'h55AA_55AA;
      tick();
      bus.pready = 1'b0;
      check_bus("t8.rsp", 1'b0, 1'b0, 1'b1);
      check("t8.rsp_err",   64'(bus.rsp_err),   64'd0);
      check("t8.rsp_rdata", 64'(bus.rsp_rdata), 64'h55AA_55AA);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
